// File: rtl/lcd_spi_pkg.sv
// Shared types and constants for the LCD panel SPI master and its input queue.
package lcd_spi_pkg;

   localparam int BITS_PER_BYTE  = 8;
   localparam int EDGES_PER_BYTE = 2 * BITS_PER_BYTE;

   typedef enum logic [2:0] {
      RESET_PULSE = 3'd0,
      IDLE        = 3'd1,
      LOAD        = 3'd2,
      SHIFT       = 3'd3,
      GAP         = 3'd4
   } state_t;

   typedef struct packed {
      logic                     dc;
      logic [BITS_PER_BYTE-1:0] data;
   } entry_t;

   // Counter width for a terminal count; never zero so one-cycle settings stay legal.
   function automatic int cnt_width(input int terminal);
      return (terminal > 1) ? $clog2(terminal) : 1;
   endfunction

endpackage

// File: rtl/lcd_spi_fifo.sv
// Synchronous entry FIFO with flush; pop_data shows the head combinationally.
module lcd_spi_fifo
   import lcd_spi_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             push,
   input  entry_t           push_data,
   input  logic             pop,
   output entry_t           pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   entry_t           mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == CNT_W'(0));
   assign count     = count_r;
   assign pop_data  = mem_r[rd_ptr_r];
   assign pop_ok_s  = pop & ~empty;
   // A pop in the same cycle frees a slot, so a full queue may still take a push.
   assign push_ok_s = push & (~full | pop_ok_s);

   // Pointer and occupancy bookkeeping; flush returns the queue to empty.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else if (flush) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_ok_s && !flush) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

endmodule

// File: rtl/lcd_spi_master.sv
// Byte-stream SPI mode-0 master for the LCD panel: queued (dc, byte) entries,
// chip-select framing across back-to-back bytes, and panel hardware-reset pulse.
module lcd_spi_master
   import lcd_spi_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int RST_CYCLES = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_dc,
   input  logic       soft_rst,
   output logic       spi_clk,
   output logic       spi_mosi,
   output logic       spi_cs,
   output logic       spi_dc,
   output logic       spi_rst,
   output logic       busy,
   output logic       done_irq
);

   localparam int DIV_W  = cnt_width(CLK_DIV);
   localparam int EDGE_W = cnt_width(EDGES_PER_BYTE);
   localparam int RST_W  = cnt_width(RST_CYCLES);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(EDGES_PER_BYTE - 1);
   localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);

   state_t                   state_r;
   logic [DIV_W-1:0]         div_cnt_r;
   logic [EDGE_W-1:0]        edge_cnt_r;
   logic [RST_W-1:0]         rst_cnt_r;
   logic [BITS_PER_BYTE-1:0] shift_r;

   entry_t                   in_entry_s;
   entry_t                   head_s;
   logic                     push_s;
   logic                     pop_s;
   logic                     fifo_full_s;
   logic                     fifo_empty_s;
   logic [CNT_W-1:0]         fifo_count_s;

   assign in_entry_s.dc   = in_dc;
   assign in_entry_s.data = in_data;
   assign in_ready        = ~fifo_full_s;
   // soft_rst wins over a coincident push or pop.
   assign push_s          = in_valid & in_ready & ~soft_rst;
   assign pop_s           = (state_r == LOAD) & ~soft_rst;

   lcd_spi_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (soft_rst),
      .push      (push_s),
      .push_data (in_entry_s),
      .pop       (pop_s),
      .pop_data  (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   // Sequencer: panel reset pulse, byte load, SCLK divider and shifter, framing.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= RESET_PULSE;
         div_cnt_r  <= DIV_W'(0);
         edge_cnt_r <= EDGE_W'(0);
         rst_cnt_r  <= RST_W'(0);
         shift_r    <= {BITS_PER_BYTE{1'b0}};
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
         spi_cs     <= 1'b1;
         spi_dc     <= 1'b0;
         spi_rst    <= 1'b0;
         busy       <= 1'b1;
         done_irq   <= 1'b0;
      end else if (soft_rst) begin
         state_r    <= RESET_PULSE;
         div_cnt_r  <= DIV_W'(0);
         edge_cnt_r <= EDGE_W'(0);
         rst_cnt_r  <= RST_W'(0);
         shift_r    <= {BITS_PER_BYTE{1'b0}};
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b0;
         spi_cs     <= 1'b1;
         spi_dc     <= 1'b0;
         spi_rst    <= 1'b0;
         busy       <= 1'b1;
         done_irq   <= 1'b0;
      end else begin
         done_irq <= 1'b0;
         case (state_r)
            RESET_PULSE: begin
               if (rst_cnt_r == RST_LAST) begin
                  spi_rst <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  rst_cnt_r <= rst_cnt_r + RST_W'(1);
               end
            end
            IDLE: begin
               if (!fifo_empty_s) begin
                  busy    <= 1'b1;
                  state_r <= LOAD;
               end else begin
                  busy <= 1'b0;
               end
            end
            LOAD: begin
               spi_cs     <= 1'b0;
               spi_dc     <= head_s.dc;
               spi_mosi   <= head_s.data[BITS_PER_BYTE-1];
               shift_r    <= head_s.data;
               spi_clk    <= 1'b0;
               div_cnt_r  <= DIV_W'(0);
               edge_cnt_r <= EDGE_W'(0);
               state_r    <= SHIFT;
            end
            SHIFT: begin
               if (div_cnt_r == DIV_LAST) begin
                  div_cnt_r <= DIV_W'(0);
                  spi_clk   <= ~spi_clk;
                  // Falling edge: present the next bit so it is stable at the next rise.
                  if (spi_clk) begin
                     spi_mosi <= shift_r[BITS_PER_BYTE-2];
                     shift_r  <= {shift_r[BITS_PER_BYTE-2:0], 1'b0};
                  end
                  if (edge_cnt_r == EDGE_LAST) begin
                     edge_cnt_r <= EDGE_W'(0);
                     if (fifo_count_s == CNT_W'(0)) begin
                        state_r <= GAP;
                     end else begin
                        state_r <= LOAD;
                     end
                  end else begin
                     edge_cnt_r <= edge_cnt_r + EDGE_W'(1);
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + DIV_W'(1);
               end
            end
            GAP: begin
               spi_cs   <= 1'b1;
               spi_clk  <= 1'b0;
               done_irq <= 1'b1;
               busy     <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               state_r   <= RESET_PULSE;
               rst_cnt_r <= RST_W'(0);
               spi_clk   <= 1'b0;
               spi_cs    <= 1'b1;
               spi_rst   <= 1'b0;
               busy      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_spi_master.sv
// Self-checking bench for lcd_spi_master: a serial monitor rebuilds bytes at SCLK
// rises and compares them against a scoreboard of accepted entries.
module tb_lcd_spi_master;

   logic       clock    = 1'b0;
   logic       reset_n  = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_dc    = 1'b0;
   logic       soft_rst = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic       in_ready;
   logic       spi_clk, spi_mosi, spi_cs, spi_dc, spi_rst, busy, done_irq;

   int         checks   = 0;
   int         errors   = 0;
   int         rx_count = 0;
   logic [8:0] sb [$];

   always #5 clock = ~clock;

   lcd_spi_master #(
      .CLK_DIV    (2),
      .FIFO_DEPTH (4),
      .RST_CYCLES (16)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_dc    (in_dc),
      .soft_rst (soft_rst),
      .spi_clk  (spi_clk),
      .spi_mosi (spi_mosi),
      .spi_cs   (spi_cs),
      .spi_dc   (spi_dc),
      .spi_rst  (spi_rst),
      .busy     (busy),
      .done_irq (done_irq)
   );

   // Serial monitor: sample mosi after each SCLK rise, compare whole bytes.
   int         mon_bits     = 0;
   logic       mon_prev_clk = 1'b0;
   logic [7:0] mon_shift    = 8'h00;
   logic [8:0] mon_exp;
   always @(negedge clock) begin
      if (!reset_n || spi_cs) begin
         mon_bits = 0;
      end else if (spi_clk && !mon_prev_clk) begin
         mon_shift = {mon_shift[6:0], spi_mosi};
         mon_bits++;
         if (mon_bits == 8) begin
            mon_bits = 0;
            rx_count++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: got dc=%0b data=%02h, required no byte", spi_dc, mon_shift);
            end else begin
               mon_exp = sb.pop_front();
               if ({spi_dc, mon_shift} !== mon_exp) begin
                  errors++;
                  $display("FAIL rx_byte: got dc=%0b data=%02h, required dc=%0b data=%02h",
                           spi_dc, mon_shift, mon_exp[8], mon_exp[7:0]);
               end
            end
         end
      end
      mon_prev_clk = spi_clk;
   end

   task automatic drive_entry(input logic dc, input logic [7:0] data, input int max_wait, output int waited);
      waited = 0;
      @(negedge clock);
      in_valid = 1'b1;
      in_dc    = dc;
      in_data  = data;
      while (!in_ready && waited < max_wait) begin
         waited++;
         @(negedge clock);
      end
      if (in_ready) sb.push_back({dc, data});
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic measure(input int max_cycles, output int low, output int irqs,
                          output int cs_rises, output bit timeout);
      logic prev_cs = 1'b1;
      bit   started = 1'b0;
      low = 0; irqs = 0; cs_rises = 0; timeout = 1'b1;
      for (int i = 0; i < max_cycles; i++) begin
         @(posedge clock);
         #1;
         if (!spi_cs) begin low++; started = 1'b1; end
         if (done_irq) irqs++;
         if (spi_cs && !prev_cs) cs_rises++;
         prev_cs = spi_cs;
         if (started && !busy) begin timeout = 1'b0; break; end
      end
      repeat (3) begin
         @(posedge clock);
         #1;
         if (done_irq) irqs++;
      end
   endtask

   task automatic count_pulse(output int n, output int rises, output int irqs, output bit cs_high);
      logic prev_clk = spi_clk;
      n = 0; rises = 0; irqs = 0; cs_high = 1'b1;
      while (n < 100) begin
         @(posedge clock);
         #1;
         n++;
         if (spi_clk && !prev_clk) rises++;
         prev_clk = spi_clk;
         if (done_irq) irqs++;
         if (!spi_cs) cs_high = 1'b0;
         if (spi_rst) break;
      end
   endtask

   task automatic wait_idle(input int max_cycles);
      int n = 0;
      while ((busy || sb.size() != 0 || !spi_cs) && n < max_cycles) begin
         @(posedge clock);
         #1;
         n++;
      end
      checks++;
      if (n >= max_cycles) begin
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles (queued=%0d), required idle", n, sb.size());
      end
   endtask

   task automatic test_reset();
      int n, rises, irqs;
      bit cs_high;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({spi_clk, spi_mosi, spi_cs, spi_dc, spi_rst, busy, done_irq, in_ready} !== 8'b0010_0101) begin
         errors++;
         $display("FAIL reset_values: got %08b, required 00100101",
                  {spi_clk, spi_mosi, spi_cs, spi_dc, spi_rst, busy, done_irq, in_ready});
      end
      @(negedge clock);
      reset_n = 1'b1;
      count_pulse(n, rises, irqs, cs_high);
      checks++;
      if (n !== 16) begin errors++; $display("FAIL reset_pulse_len: got %0d, required 16", n); end
      checks++;
      if (cs_high !== 1'b1 || rises !== 0) begin
         errors++; $display("FAIL reset_cs_idle: got cs_high=%0b rises=%0d, required 1 and 0", cs_high, rises);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
   endtask

   task automatic test_single();
      int w, low, irqs, rises;
      bit to;
      drive_entry(1'b1, 8'hA5, 10, w);
      measure(200, low, irqs, rises, to);
      checks++;
      if (to !== 1'b0 || low !== 33) begin
         errors++; $display("FAIL single_cs_low: got %0d cycles (timeout=%0b), required 33", low, to);
      end
      checks++;
      if (irqs !== 1) begin errors++; $display("FAIL single_irq: got %0d pulses, required 1", irqs); end
      checks++;
      if (rises !== 1) begin errors++; $display("FAIL single_cs_frames: got %0d, required 1", rises); end
      wait_idle(100);
   endtask

   task automatic test_back_to_back();
      int w, low, irqs, rises;
      bit to;
      drive_entry(1'b0, 8'h2A, 10, w);
      drive_entry(1'b1, 8'h55, 10, w);
      measure(300, low, irqs, rises, to);
      checks++;
      if (to !== 1'b0 || low !== 66) begin
         errors++; $display("FAIL b2b_cs_low: got %0d cycles (timeout=%0b), required 66", low, to);
      end
      checks++;
      if (rises !== 1) begin errors++; $display("FAIL b2b_cs_frames: got %0d, required 1", rises); end
      checks++;
      if (irqs !== 1) begin errors++; $display("FAIL b2b_irq: got %0d pulses, required 1", irqs); end
      wait_idle(100);
   endtask

   task automatic test_fill_in_reset();
      int w, rx0;
      rx0 = rx_count;
      @(negedge clock);
      soft_rst = 1'b1;
      @(posedge clock);
      #1;
      soft_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_entry(i[0], 8'h01 + 8'(i), 10, w);
         checks++;
         if (w !== 0) begin errors++; $display("FAIL fill_accept_%0d: waited %0d, required 0", i, w); end
      end
      checks++;
      if (in_ready !== 1'b0 || spi_rst !== 1'b0) begin
         errors++; $display("FAIL fill_full: got in_ready=%0b spi_rst=%0b, required 0 and 0", in_ready, spi_rst);
      end
      drive_entry(1'b1, 8'h05, 100, w);
      checks++;
      if (w == 0 || w >= 100) begin errors++; $display("FAIL fill_fifth_held: waited %0d, required 1..99", w); end
      wait_idle(600);
      checks++;
      if (rx_count - rx0 !== 5) begin
         errors++; $display("FAIL fill_rx_count: got %0d, required 5", rx_count - rx0);
      end
   endtask

   task automatic test_soft_rst_mid();
      int w, rises, n, irqs, rx0, lows;
      bit cs_high;
      logic prev_clk;
      drive_entry(1'b1, 8'hFF, 10, w);
      drive_entry(1'b0, 8'h11, 10, w);
      drive_entry(1'b1, 8'h22, 10, w);
      rises = 0;
      prev_clk = spi_clk;
      for (int i = 0; i < 200 && rises < 3; i++) begin
         @(posedge clock);
         #1;
         if (spi_clk && !prev_clk) rises++;
         prev_clk = spi_clk;
      end
      checks++;
      if (rises !== 3) begin errors++; $display("FAIL soft_third_rise: got %0d rises, required 3", rises); end
      rx0 = rx_count;
      soft_rst = 1'b1;
      in_valid = 1'b1;
      in_dc    = 1'b1;
      in_data  = 8'h33;
      @(posedge clock);
      #1;
      soft_rst = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      checks++;
      if ({spi_cs, spi_clk, spi_mosi, spi_rst, done_irq, busy, in_ready} !== 7'b1000011) begin
         errors++;
         $display("FAIL soft_outputs: got %07b, required 1000011",
                  {spi_cs, spi_clk, spi_mosi, spi_rst, done_irq, busy, in_ready});
      end
      count_pulse(n, rises, irqs, cs_high);
      checks++;
      if (n !== 16) begin errors++; $display("FAIL soft_pulse_len: got %0d, required 16", n); end
      checks++;
      if (rises !== 0 || irqs !== 0 || cs_high !== 1'b1) begin
         errors++; $display("FAIL soft_quiet: got rises=%0d irqs=%0d cs_high=%0b, required 0 0 1", rises, irqs, cs_high);
      end
      lows = 0;
      repeat (60) begin
         @(posedge clock);
         #1;
         if (!spi_cs || done_irq) lows++;
      end
      checks++;
      if (lows !== 0 || rx_count !== rx0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL soft_flushed: got activity=%0d new_bytes=%0d busy=%0b, required 0 0 0", lows, rx_count - rx0, busy);
      end
   endtask

   task automatic test_async_reset();
      int w, rises, n, irqs, rx0;
      bit cs_high;
      logic prev_clk;
      drive_entry(1'b0, 8'hC3, 10, w);
      rises = 0;
      prev_clk = spi_clk;
      for (int i = 0; i < 200 && rises < 4; i++) begin
         @(posedge clock);
         #1;
         if (spi_clk && !prev_clk) rises++;
         prev_clk = spi_clk;
      end
      #2;
      reset_n = 1'b0;
      #1;
      sb.delete();
      checks++;
      if ({spi_clk, spi_mosi, spi_cs, spi_dc, spi_rst, busy, done_irq, in_ready} !== 8'b0010_0101) begin
         errors++;
         $display("FAIL async_reset_values: got %08b, required 00100101",
                  {spi_clk, spi_mosi, spi_cs, spi_dc, spi_rst, busy, done_irq, in_ready});
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      count_pulse(n, rises, irqs, cs_high);
      checks++;
      if (n !== 16 || rises !== 0 || cs_high !== 1'b1) begin
         errors++;
         $display("FAIL async_release: got len=%0d rises=%0d cs_high=%0b, required 16 0 1", n, rises, cs_high);
      end
      rx0 = rx_count;
      drive_entry(1'b0, 8'h3C, 10, w);
      wait_idle(200);
      checks++;
      if (rx_count - rx0 !== 1) begin
         errors++; $display("FAIL async_recover: got %0d bytes, required 1", rx_count - rx0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fill_in_reset();
      test_soft_rst_mid();
      test_async_reset();
      checks++;
      if (sb.size() !== 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
